// File: rtl/sram_port_arbiter.sv
// Arbiter sharing one single-port SRAM between instruction fetch and EX data.
// Optional SRAM_ARB_STATS_EN adds conflict and fetch-stall counters.
module sram_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_rdata_valid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_rdata_valid,
    output logic [31:0]       data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       inst_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INST,
        OWN_DATA
    } owner_t;

    localparam logic [3:0] MAX_S = 4'(MAX_DATA_STREAK);

    owner_t     owner;
    logic [3:0] streak;
    logic       gnt_inst;
    logic       gnt_data;

    // Grant decision: data wins unless fetch has waited MAX_S data grants
    always_comb begin
        gnt_data = 1'b0;
        gnt_inst = 1'b0;
        if (resetn) begin
            gnt_data = data_req && (!inst_req || (streak < MAX_S));
            gnt_inst = inst_req && !gnt_data;
        end
    end

    // Drive the SRAM and the accept strobes from the grant
    always_comb begin
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        sram_en      = gnt_inst | gnt_data;
        sram_we      = 4'b0;
        sram_addr    = '0;
        sram_wdata   = 32'b0;
        if (gnt_data) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            if (data_wr)
                sram_we = data_wstrb;
        end else if (gnt_inst) begin
            sram_addr = inst_addr;
        end
    end

    // Route SRAM read data to the owner of last cycle's read
    always_comb begin
        inst_rdata_valid = resetn && (owner == OWN_INST);
        data_rdata_valid = resetn && (owner == OWN_DATA);
        inst_rdata       = inst_rdata_valid ? sram_rdata : 32'b0;
        data_rdata       = data_rdata_valid ? sram_rdata : 32'b0;
    end

    // Track read owner and the data-over-fetch streak
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner  <= OWN_NONE;
            streak <= 4'd0;
        end else begin
            if (gnt_inst)
                owner <= OWN_INST;
            else if (gnt_data && !data_wr)
                owner <= OWN_DATA;
            else
                owner <= OWN_NONE;

            if (gnt_inst || !inst_req)
                streak <= 4'd0;
            else if (gnt_data && (streak < MAX_S))
                streak <= streak + 4'd1;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    // Saturating counters of contention and fetch stall cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            conflict_cnt   <= 32'd0;
            inst_stall_cnt <= 32'd0;
        end else begin
            if (inst_req && data_req && (conflict_cnt != 32'hFFFF_FFFF))
                conflict_cnt <= conflict_cnt + 32'd1;
            if (inst_req && !gnt_inst && (inst_stall_cnt != 32'hFFFF_FFFF))
                inst_stall_cnt <= inst_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed + constrained-random bench for sram_port_arbiter.
// Scoreboard queue predicts read responses from a reference memory.
module tb_sram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int MAXS   = 4;

    logic              clk;
    logic              resetn;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_rdata_valid;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_rdata_valid;
    logic [31:0]       data_rdata;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
`ifdef SRAM_ARB_STATS_EN
    logic [31:0]       conflict_cnt;
    logic [31:0]       inst_stall_cnt;
`endif

    sram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok),
        .inst_rdata_valid(inst_rdata_valid),
        .inst_rdata(inst_rdata),
        .data_req(data_req),
        .data_wr(data_wr),
        .data_wstrb(data_wstrb),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_rdata_valid(data_rdata_valid),
        .data_rdata(data_rdata),
        .sram_en(sram_en),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
`ifdef SRAM_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .inst_stall_cnt(inst_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: 1-cycle read, write-first
    logic [31:0] mem [logic [31:0]];

    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_en) begin
            w = mem.exists(sram_addr) ? mem[sram_addr] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (sram_we[b])
                    w[8*b +: 8] = sram_wdata[8*b +: 8];
            if (sram_we != 4'd0)
                mem[sram_addr] = w;
            sram_rdata <= w;
        end
    end

    typedef struct {
        int          cyc;
        bit          is_inst;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] ref_mem [logic [31:0]];
    int          vectors;
    int          miscompares;
    int          cyc;
    int          m_streak;
    logic        last_gi;
    logic        last_gd;

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'd0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic        gi;
        logic        gd;
        logic        hit;
        resp_t       r;
        logic [31:0] w;
        if (!resetn) begin
            chk("rst_inst_ok", 32'(inst_addr_ok), 0);
            chk("rst_data_ok", 32'(data_addr_ok), 0);
            chk("rst_en", 32'(sram_en), 0);
            chk("rst_we", 32'(sram_we), 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_wdata", sram_wdata, 0);
            chk("rst_ivalid", 32'(inst_rdata_valid), 0);
            chk("rst_dvalid", 32'(data_rdata_valid), 0);
            chk("rst_irdata", inst_rdata, 0);
            chk("rst_drdata", data_rdata, 0);
            sb.delete();
            m_streak = 0;
            last_gi  = 1'b0;
            last_gd  = 1'b0;
            cyc++;
            return;
        end
        gd = data_req && (!inst_req || m_streak < MAXS);
        gi = inst_req && !gd;
        chk("inst_addr_ok", 32'(inst_addr_ok), 32'(gi));
        chk("data_addr_ok", 32'(data_addr_ok), 32'(gd));
        chk("sram_en", 32'(sram_en), 32'(gi | gd));
        chk("sram_we", 32'(sram_we),
            (gd && data_wr) ? 32'(data_wstrb) : 32'd0);
        if (gd) begin
            chk("sram_addr_d", sram_addr, data_addr);
            chk("sram_wdata", sram_wdata, data_wdata);
        end else if (gi) begin
            chk("sram_addr_i", sram_addr, inst_addr);
        end
        hit = (sb.size() > 0) && (sb[0].cyc == cyc);
        r   = '{cyc: 0, is_inst: 1'b0, data: 32'd0};
        if (hit)
            r = sb.pop_front();
        chk("inst_rvalid", 32'(inst_rdata_valid), 32'(hit && r.is_inst));
        chk("data_rvalid", 32'(data_rdata_valid), 32'(hit && !r.is_inst));
        chk("inst_rdata", inst_rdata, (hit && r.is_inst) ? r.data : 0);
        chk("data_rdata", data_rdata, (hit && !r.is_inst) ? r.data : 0);
        if (gi)
            sb.push_back('{cyc: cyc + 1, is_inst: 1'b1,
                           data: ref_rd(inst_addr)});
        if (gd && !data_wr)
            sb.push_back('{cyc: cyc + 1, is_inst: 1'b0,
                           data: ref_rd(data_addr)});
        if (gd && data_wr) begin
            w = ref_rd(data_addr);
            for (int b = 0; b < 4; b++)
                if (data_wstrb[b])
                    w[8*b +: 8] = data_wdata[8*b +: 8];
            ref_mem[data_addr] = w;
        end
        if (gi || !inst_req)
            m_streak = 0;
        else if (gd && m_streak < MAXS)
            m_streak++;
        last_gi = gi;
        last_gd = gd;
        cyc++;
    endtask

    task automatic tick(int ei = -1, int ed = -1);
        @(negedge clk);
        if (ei >= 0)
            chk("dir_inst_ok", 32'(inst_addr_ok), 32'(ei));
        if (ed >= 0)
            chk("dir_data_ok", 32'(data_addr_ok), 32'(ed));
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(logic req, logic wr, logic [31:0] a,
                            logic [3:0] s, logic [31:0] d);
        data_req   = req;
        data_wr    = wr;
        data_addr  = a;
        data_wstrb = s;
        data_wdata = d;
    endtask

    logic [31:0] addr_pool [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        m_streak    = 0;
        last_gi     = 1'b0;
        last_gd     = 1'b0;
        sram_rdata  = 32'd0;
        addr_pool[0] = 32'h1C00_0000;
        addr_pool[1] = 32'h0000_0100;
        addr_pool[2] = 32'h0000_0200;
        addr_pool[3] = 32'h0000_0104;
        mem[32'h1C00_0000]     = 32'h0280_0C0C;
        ref_mem[32'h1C00_0000] = 32'h0280_0C0C;
        mem[32'h0000_0100]     = 32'h1234_5678;
        ref_mem[32'h0000_0100] = 32'h1234_5678;
        mem[32'h0000_0200]     = 32'h1122_3344;
        ref_mem[32'h0000_0200] = 32'h1122_3344;
        mem[32'h1C00_0004]     = 32'hCAFE_0004;
        ref_mem[32'h1C00_0004] = 32'hCAFE_0004;

        // reset with both requests asserted: outputs must stay zero
        resetn    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        set_data(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        tick();
        tick();
        resetn   = 1'b1;
        inst_req = 1'b0;
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(0, 0);

        // lone fetch
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        tick(1, 0);
        inst_req = 1'b0;
        @(negedge clk);
        chk("fetch_word", inst_rdata, 32'h0280_0C0C);
        @(posedge clk);
        #1;
        @(negedge clk);
        cyc = cyc - 0;
        @(posedge clk);
        #1;
        // previous two edges: response cycle was consumed unchecked by the
        // scoreboard; resync by flushing the stale entry
        sb.delete();
        tick(0, 0);

        // conflict: data wins at streak 0, then fetch goes through
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0004;
        set_data(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        tick(0, 1);
        data_req = 1'b0;
        tick(1, 0);
        inst_req = 1'b0;
        tick(0, 0);

        // starvation bound
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        for (int i = 0; i < 4; i++) begin
            set_data(1'b1, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
            tick(0, 1);
        end
        set_data(1'b1, 1'b0, 32'h110, 4'h0, 32'h0);
        tick(1, 0);
        inst_addr = 32'h1C00_0004;
        tick(0, 1);
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(1, 0);
        inst_req = 1'b0;
        tick(0, 0);

        // partial store, then load of the same word
        set_data(1'b1, 1'b1, 32'h200, 4'b0011, 32'hAABB_CCDD);
        tick(0, 1);
        set_data(1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
        tick(0, 1);
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("merged_word", data_rdata, 32'h1122_CCDD);
        check_cycle();
        @(posedge clk);
        #1;

        // reset with a load in flight
        set_data(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        tick(0, 1);
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick(0, 0);
        tick(0, 0);
        set_data(1'b1, 1'b0, 32'h200, 4'h0, 32'h0);
        tick(0, 1);
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(0, 0);

`ifdef SRAM_ARB_STATS_EN
        resetn = 1'b0;
        tick();
        resetn    = 1'b1;
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0000;
        for (int i = 0; i < 3; i++) begin
            set_data(1'b1, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
            tick(0, 1);
        end
        inst_req = 1'b0;
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(0, 0);
        tick(0, 0);
        chk("conflict_cnt", conflict_cnt, 32'd3);
        chk("inst_stall_cnt", inst_stall_cnt, 32'd3);
`endif

        // constrained random traffic honouring the hold-until-accept rule
        for (int n = 0; n < 200; n++) begin
            if (!inst_req || last_gi) begin
                inst_req  = 1'($urandom_range(0, 1));
                inst_addr = addr_pool[$urandom_range(0, 3)];
            end
            if (!data_req || last_gd) begin
                set_data(1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)),
                         addr_pool[$urandom_range(0, 3)],
                         4'($urandom_range(1, 15)),
                         32'($urandom));
            end
            tick();
        end
        inst_req = 1'b0;
        set_data(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick(0, 0);
        tick(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
